cjb_stack_ctrl_v: RTL

- Sequencing and arbitration controller for the 4-location n-bit hardware stack used by the RISC processor's push/pop instructions.
- Two requesters share one stack through a req/ack handshake:
  - A: execute unit PUSH/POP.
  - B: call/return unit.
- Tracks occupancy, blocks pushes when full and pops when empty, and raises sticky overflow/underflow flags.
- Returns pop data to the requester that issued the pop.

---
 rtl/cjb_stack_ctrl_v.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/cjb_stack_ctrl_v.sv
`default_nettype none
// ============================================================================
// Module   : cjb_stack_ctrl_v
// Brief    : Two-requester arbitration and sequencing controller for the
//            4-location hardware stack (PUSH/POP and call/return units).
//            Tracks occupancy, suppresses illegal strobes, keeps sticky
//            overflow/underflow flags and routes pop data back to its owner.
// Revision : 1.0 - initial release
// ============================================================================
module cjb_stack_ctrl_v #(
  parameter int n = 8,
  parameter int d = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         a_req,
  input  logic         a_op,
  input  logic [n-1:0] a_din,
  output logic         a_ack,
  input  logic         b_req,
  input  logic         b_op,
  input  logic [n-1:0] b_din,
  output logic         b_ack,
  output logic [n-1:0] rdata,
  output logic         rvalid,
  output logic         rsel,
  output logic         stk_push,
  output logic         stk_pop,
  output logic [n-1:0] stk_din,
  input  logic [n-1:0] stk_dout,
  output logic [2:0]   depth,
  output logic         full,
  output logic         empty,
  output logic         ovf,
  output logic         unf,
  input  logic         err_clr
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] POP_RD = 2'd2;

  localparam logic [2:0] DEPTH_MAX = 3'(d);

  logic [1:0]   state;
  logic         prio_b;   // 1: B wins when both request (A was granted last)
  logic         g_sel;    // grantee: 0 = A, 1 = B
  logic         g_op;     // granted operation: 0 = push, 1 = pop
  logic         g_legal;  // granted operation was legal at grant time

  logic         req_any;
  logic         pick_b;
  logic         pick_op;
  logic         pick_legal;
  logic [n-1:0] pick_din;

  // Arbitration choice and legality of the candidate request in IDLE
  always_comb begin
    req_any    = a_req | b_req;
    pick_b     = (a_req && b_req) ? prio_b : b_req;
    pick_op    = pick_b ? b_op  : a_op;
    pick_din   = pick_b ? b_din : a_din;
    pick_legal = pick_op ? (depth != 3'd0) : (depth < DEPTH_MAX);
  end

  assign full  = (depth == DEPTH_MAX);
  assign empty = (depth == 3'd0);

  // Grant / issue / pop-read sequencer with registered outputs and flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      prio_b   <= 1'b0;
      g_sel    <= 1'b0;
      g_op     <= 1'b0;
      g_legal  <= 1'b0;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      stk_push <= 1'b0;
      stk_pop  <= 1'b0;
      stk_din  <= '0;
      rdata    <= '0;
      rvalid   <= 1'b0;
      rsel     <= 1'b0;
      depth    <= 3'd0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else begin
      // Pulses default low; a new error in ISSUE overrides the clear below
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      stk_push <= 1'b0;
      stk_pop  <= 1'b0;
      rvalid   <= 1'b0;
      ovf      <= ovf & ~err_clr;
      unf      <= unf & ~err_clr;

      case (state)
        IDLE: begin
          if (req_any) begin
            state   <= ISSUE;
            g_sel   <= pick_b;
            g_op    <= pick_op;
            g_legal <= pick_legal;
            prio_b  <= ~pick_b;
            a_ack   <= ~pick_b;
            b_ack   <= pick_b;
            if (pick_legal) begin
              if (pick_op) begin
                stk_pop <= 1'b1;
              end else begin
                stk_push <= 1'b1;
                stk_din  <= pick_din;
              end
            end
          end
        end

        ISSUE: begin
          if (g_legal) begin
            depth <= g_op ? (depth - 3'd1) : (depth + 3'd1);
          end else if (g_op) begin
            unf <= 1'b1;
          end else begin
            ovf <= 1'b1;
          end
          state <= g_op ? POP_RD : IDLE;
        end

        POP_RD: begin
          // An illegal pop still answers, with zero data, so nobody waits forever
          rdata  <= g_legal ? stk_dout : '0;
          rsel   <= g_sel;
          rvalid <= 1'b1;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
